// File: rtl/redma_sched_pkg.sv
// Shared types and constants for the write command scheduler.
package redma_sched_pkg;
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    RUN,
    DRAIN,
    DONE
  } sched_state_t;
endpackage

// File: rtl/write_cmd_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last grant,
// remembering the winner only when the caller advances.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] idx_v;
  logic             found;
  int               idx;

  always_comb begin
    grant     = '0;
    grant_idx = last_q;
    found     = 1'b0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = IDX_W'(idx);
      if (!found && req[idx_v]) begin
        found        = 1'b1;
        grant[idx_v] = 1'b1;
        grant_idx    = idx_v;
      end
    end
    last_d = (advance && found) ? grant_idx : last_q;
  end

  // Reset to the top index so requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= IDX_W'(NUM_REQ - 1);
    else     last_q <= last_d;
  end
endmodule

// File: rtl/write_cmd_scheduler.sv
// Accepts write commands from several requesters, starts the write engine,
// throttles AW issue against outstanding B responses and signals completion.
module write_cmd_scheduler
  import redma_sched_pkg::*;
#(
  parameter int NUM_REQ             = 4,
  parameter int INTERNAL_ADDR_WIDTH = 32,
  parameter int BTT_WIDTH           = 23,
  parameter int MAX_OUTSTANDING     = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_ready,
  input  logic [NUM_REQ*INTERNAL_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*BTT_WIDTH-1:0]           req_btt,
  output logic [NUM_REQ-1:0]                     done,
  output logic                                   eng_start,
  output logic [INTERNAL_ADDR_WIDTH-1:0]         eng_start_addr,
  output logic [BTT_WIDTH-1:0]                   eng_btt,
  output logic                                   eng_enable,
  input  logic                                   eng_new_transaction,
  input  logic                                   eng_last_transaction,
  input  logic                                   bvalid,
  output logic                                   bready,
  output logic                                   busy
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] MAX_OUT = CNT_W'(MAX_OUTSTANDING);

  sched_state_t               state_q, state_d;
  logic [CNT_W-1:0]           aw_cnt_q, aw_cnt_d, b_cnt_q, b_cnt_d, b_next, diff;
  logic [IDX_W-1:0]           grant_idx_q, grant_idx_d;
  logic [INTERNAL_ADDR_WIDTH-1:0] addr_q, addr_d, addr_sel;
  logic [BTT_WIDTH-1:0]       btt_q, btt_d, btt_sel;
  logic                       armed_q;
  logic                       eng_start_q, eng_start_d, eng_enable_q, eng_enable_d;
  logic                       bready_q, bready_d, busy_q, busy_d;
  logic [NUM_REQ-1:0]         done_q, done_d;
  logic [NUM_REQ-1:0]         arb_grant;
  logic [IDX_W-1:0]           arb_idx;
  logic                       advance, aw_hs, b_hs;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (advance),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign addr_sel = req_addr[int'(arb_idx)*INTERNAL_ADDR_WIDTH +: INTERNAL_ADDR_WIDTH];
  assign btt_sel  = req_btt[int'(arb_idx)*BTT_WIDTH +: BTT_WIDTH];

  // armed_q holds off grants in the first cycle after reset release.
  assign advance   = (state_q == IDLE) && armed_q && (|req_valid);
  assign req_ready = advance ? arb_grant : '0;
  assign aw_hs     = eng_new_transaction && (state_q == RUN);
  // A B response with nothing outstanding is stray and not counted.
  assign b_hs      = bvalid && bready_q && (aw_cnt_q != b_cnt_q);
  assign b_next    = b_cnt_q + CNT_W'(b_hs);

  always_comb begin
    state_d     = state_q;
    grant_idx_d = grant_idx_q;
    addr_d      = addr_q;
    btt_d       = btt_q;
    aw_cnt_d    = aw_cnt_q + CNT_W'(aw_hs);
    b_cnt_d     = b_next;
    case (state_q)
      IDLE: if (advance) begin
        grant_idx_d = arb_idx;
        addr_d      = addr_sel;
        btt_d       = btt_sel;
        state_d     = (btt_sel == '0) ? DONE : START;
      end
      START: state_d = RUN;
      RUN:   if (aw_hs && eng_last_transaction) state_d = DRAIN;
      DRAIN: if (b_next == aw_cnt_q) state_d = DONE;
      DONE: begin
        state_d  = IDLE;
        aw_cnt_d = '0;
        b_cnt_d  = '0;
      end
      default: state_d = IDLE;
    endcase

    diff         = aw_cnt_d - b_cnt_d;
    eng_start_d  = (state_d == START);
    bready_d     = (state_d == RUN) || (state_d == DRAIN);
    busy_d       = (state_d != IDLE);
    eng_enable_d = (state_d == RUN) && (diff < MAX_OUT);
    done_d       = '0;
    if (state_d == DONE) done_d[grant_idx_d] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      aw_cnt_q     <= '0;
      b_cnt_q      <= '0;
      grant_idx_q  <= '0;
      addr_q       <= '0;
      btt_q        <= '0;
      armed_q      <= 1'b0;
      eng_start_q  <= 1'b0;
      eng_enable_q <= 1'b0;
      bready_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      aw_cnt_q     <= aw_cnt_d;
      b_cnt_q      <= b_cnt_d;
      grant_idx_q  <= grant_idx_d;
      addr_q       <= addr_d;
      btt_q        <= btt_d;
      armed_q      <= 1'b1;
      eng_start_q  <= eng_start_d;
      eng_enable_q <= eng_enable_d;
      bready_q     <= bready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign eng_start      = eng_start_q;
  assign eng_start_addr = addr_q;
  assign eng_btt        = btt_q;
  assign eng_enable     = eng_enable_q;
  assign bready         = bready_q;
  assign busy           = busy_q;
  assign done           = done_q;
endmodule

// File: tb/tb_write_cmd_scheduler.sv
// Directed bench for write_cmd_scheduler: grant order, engine throttling,
// zero-length commands, same-cycle AW/B and asynchronous reset mid-command.
module tb_write_cmd_scheduler;
  logic          clk;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [127:0]  req_addr;
  logic [91:0]   req_btt;
  logic [3:0]    done;
  logic          eng_start;
  logic [31:0]   eng_start_addr;
  logic [22:0]   eng_btt;
  logic          eng_enable;
  logic          eng_new_transaction;
  logic          eng_last_transaction;
  logic          bvalid;
  logic          bready;
  logic          busy;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int done_cnt  = 0;

  write_cmd_scheduler #(
    .NUM_REQ(4), .INTERNAL_ADDR_WIDTH(32), .BTT_WIDTH(23), .MAX_OUTSTANDING(2)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_ready            (req_ready),
    .req_addr             (req_addr),
    .req_btt              (req_btt),
    .done                 (done),
    .eng_start            (eng_start),
    .eng_start_addr       (eng_start_addr),
    .eng_btt              (eng_btt),
    .eng_enable           (eng_enable),
    .eng_new_transaction  (eng_new_transaction),
    .eng_last_transaction (eng_last_transaction),
    .bvalid               (bvalid),
    .bready               (bready),
    .busy                 (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (eng_start === 1'b1) start_cnt++;
    if (done !== 4'b0000) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [22:0] b);
    req_addr[i*32 +: 32] = a;
    req_btt[i*23 +: 23]  = b;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    #1;
    while (req_ready == 4'b0000 && n < 40) begin
      tick();
      #1;
      n++;
    end
    chk("grant_wait_in_bound", 64'(n < 40), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_eng_start"}, 64'(eng_start), 64'd0);
    chk({tag, "_eng_enable"}, 64'(eng_enable), 64'd0);
    chk({tag, "_bready"}, 64'(bready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_start_addr"}, 64'(eng_start_addr), 64'd0);
    chk({tag, "_eng_btt"}, 64'(eng_btt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued, resp, sc0, dc0, c;
    bit finished, do_aw, do_b, b_hs;
    int bq[$];
    int order[6];
    logic [3:0] vmask;

    rst = 1'b1; req_valid = '0; req_addr = '0; req_btt = '0;
    eng_new_transaction = 1'b0; eng_last_transaction = 1'b0; bvalid = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single command, two bursts, two B responses
    set_req(0, 32'h1000, 23'd512);
    req_valid = 4'b0001;
    #1;
    chk("t1_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = 4'b0000;
    chk("t1_start", 64'(eng_start), 64'd1);
    chk("t1_start_addr", 64'(eng_start_addr), 64'h1000);
    chk("t1_btt", 64'(eng_btt), 64'd512);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_bready_start", 64'(bready), 64'd0);
    tick();
    chk("t1_start_off", 64'(eng_start), 64'd0);
    chk("t1_bready_run", 64'(bready), 64'd1);
    chk("t1_enable_0", 64'(eng_enable), 64'd1);
    eng_new_transaction = 1'b1;
    tick();
    chk("t1_enable_1", 64'(eng_enable), 64'd1);
    eng_last_transaction = 1'b1;
    tick();
    eng_new_transaction = 1'b0; eng_last_transaction = 1'b0;
    chk("t1_enable_drain", 64'(eng_enable), 64'd0);
    chk("t1_bready_drain", 64'(bready), 64'd1);
    bvalid = 1'b1;
    tick();
    chk("t1_done_early", 64'(done), 64'd0);
    tick();
    bvalid = 1'b0;
    chk("t1_done", 64'(done), 64'h1);
    $display("cmd req0 addr=0x1000 btt=512 completed");
    tick();
    chk("t1_done_off", 64'(done), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);
    chk("t1_start_count", 64'(start_cnt), 64'd1);

    // Round-robin order from reset, all zero-length commands
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) set_req(i, 32'h100 * (i + 1), 23'd0);
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 1; order[5] = 3;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      if (k == 4) req_valid = 4'b1010;
      wait_ready();
      vmask = 4'b0001 << order[k];
      chk("t2_grant", 64'(req_ready), 64'(vmask));
      tick();
      req_valid = req_valid & ~vmask;
      chk("t2_done", 64'(done), 64'(vmask));
      $display("cmd req%0d zero-length completed", order[k]);
      tick();
      chk("t2_done_off", 64'(done), 64'd0);
    end

    // Zero-length command on requester 2 never starts the engine
    sc0 = start_cnt;
    set_req(2, 32'h2200, 23'd0);
    req_valid = 4'b0100;
    wait_ready();
    chk("t3_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = 4'b0000;
    chk("t3_done", 64'(done), 64'h4);
    chk("t3_busy", 64'(busy), 64'd1);
    chk("t3_no_start", 64'(eng_start), 64'd0);
    $display("cmd req2 btt=0 completed");
    tick();
    chk("t3_done_off", 64'(done), 64'd0);
    chk("t3_busy_off", 64'(busy), 64'd0);
    chk("t3_start_count", 64'(start_cnt), 64'(sc0));

    // Five bursts with B responses delayed 20 cycles, at most 2 outstanding
    set_req(0, 32'h2000, 23'd1280);
    req_valid = 4'b0001;
    wait_ready();
    tick();
    req_valid = 4'b0000;
    chk("t4_start", 64'(eng_start), 64'd1);
    tick();
    issued = 0; resp = 0; finished = 1'b0;
    for (c = 0; c < 300 && !finished; c++) begin
      chk("t4_enable", 64'(eng_enable), 64'((issued < 5) && (issued - resp < 2)));
      do_aw = (eng_enable === 1'b1) && (issued < 5);
      eng_new_transaction  = do_aw;
      eng_last_transaction = do_aw && (issued == 4);
      do_b = (bq.size() > 0) && (c >= bq[0] + 20);
      bvalid = do_b;
      b_hs = do_b && (bready === 1'b1);
      tick();
      if (do_aw) begin
        issued++;
        bq.push_back(c);
      end
      if (b_hs) begin
        void'(bq.pop_front());
        resp++;
      end
      chk("t4_outstanding_le2", 64'((issued - resp) <= 2), 64'd1);
      if (resp == 5) begin
        chk("t4_done", 64'(done), 64'h1);
        finished = 1'b1;
      end
    end
    eng_new_transaction = 1'b0; eng_last_transaction = 1'b0; bvalid = 1'b0;
    chk("t4_finished_in_bound", 64'(finished), 64'd1);
    $display("cmd req0 addr=0x2000 bursts=%0d bresp=%0d completed", issued, resp);
    tick();
    chk("t4_idle", 64'(busy), 64'd0);

    // Stray B ignored; same-cycle AW and B keep the difference
    set_req(1, 32'h3000, 23'd100);
    req_valid = 4'b0010;
    wait_ready();
    chk("t5_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 4'b0000;
    tick();
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("t5_stray_b_ignored", 64'(eng_enable), 64'd1);
    eng_new_transaction = 1'b1;
    tick();
    chk("t5_enable_1out", 64'(eng_enable), 64'd1);
    bvalid = 1'b1;
    tick();
    chk("t5_enable_aw_b_same", 64'(eng_enable), 64'd1);
    bvalid = 1'b0; eng_last_transaction = 1'b1;
    tick();
    eng_new_transaction = 1'b0; eng_last_transaction = 1'b0;
    chk("t5_enable_drain", 64'(eng_enable), 64'd0);
    bvalid = 1'b1;
    tick();
    chk("t5_done_early", 64'(done), 64'd0);
    tick();
    bvalid = 1'b0;
    chk("t5_done", 64'(done), 64'h2);
    $display("cmd req1 addr=0x3000 same-cycle AW/B completed");
    tick();
    chk("t5_idle", 64'(busy), 64'd0);

    // Asynchronous reset in RUN with three outstanding bursts
    set_req(0, 32'h4000, 23'd300);
    req_valid = 4'b0001;
    wait_ready();
    tick();
    req_valid = 4'b0000;
    tick();
    eng_new_transaction = 1'b1;
    repeat (3) tick();
    eng_new_transaction = 1'b0;
    chk("t6_busy_run", 64'(busy), 64'd1);
    chk("t6_enable_3out", 64'(eng_enable), 64'd0);
    chk("t6_addr_run", 64'(eng_start_addr), 64'h4000);
    dc0 = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("t6_async");
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("t6_no_done", 64'(done_cnt), 64'(dc0));
    $display("cmd req0 addr=0x4000 abandoned by reset");
    set_req(3, 32'hABC0, 23'd16);
    req_valid = 4'b1000;
    wait_ready();
    chk("t6_ready_after_rst", 64'(req_ready), 64'h8);
    tick();
    req_valid = 4'b0000;
    chk("t6_start", 64'(eng_start), 64'd1);
    chk("t6_start_addr", 64'(eng_start_addr), 64'hABC0);
    chk("t6_btt", 64'(eng_btt), 64'd16);
    tick();
    eng_new_transaction = 1'b1; eng_last_transaction = 1'b1;
    tick();
    eng_new_transaction = 1'b0; eng_last_transaction = 1'b0;
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    chk("t6_done", 64'(done), 64'h8);
    $display("cmd req3 addr=0xabc0 btt=16 completed");
    tick();
    chk("t6_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/write_cmd_scheduler.md
WRITE_CMD_SCHEDULER -- requirements
Module: write_cmd_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of command requesters (2..8).
REQ-002 SHALL have parameter INTERNAL_ADDR_WIDTH, default 32, command address width.
REQ-003 SHALL have parameter BTT_WIDTH, default 23, bytes-to-transfer width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 8, max AW bursts issued without a B response (1..255).
REQ-005 SHALL have the following ports; one clock, reset asynchronous and active-high:
  clk  input  1  clock
  rst  input  1  asynchronous active-high reset
  req_valid  input  NUM_REQ  per-requester command valid
  req_ready  output  NUM_REQ  per-requester command accept
  req_addr  input  NUM_REQ*INTERNAL_ADDR_WIDTH  packed start addresses, requester i at slice i
  req_btt  input  NUM_REQ*BTT_WIDTH  packed byte counts
  done  output  NUM_REQ  one-cycle completion pulse per requester
  eng_start  output  1  one-cycle start pulse to write engine
  eng_start_addr  output  INTERNAL_ADDR_WIDTH  registered start address
  eng_btt  output  BTT_WIDTH  registered byte count
  eng_enable  output  1  permits engine to issue next AW
  eng_new_transaction  input  1  engine AW handshake this cycle
  eng_last_transaction  input  1  engine is on final burst
  bvalid  input  1  AXI write response valid
  bready  output  1  AXI write response ready
  busy  output  1  command in flight

Function
REQ-006 SHALL run FSM states IDLE, START, RUN, DRAIN, DONE.
REQ-007 IDLE: if any req_valid, SHALL grant one requester round-robin, pulse req_ready[grant] for that cycle, latch addr/btt/grant index.
REQ-008 Round-robin SHALL begin searching at index (last_grant+1) mod NUM_REQ; last_grant resets to NUM_REQ-1 so requester 0 wins first.
REQ-009 Latched btt==0 SHALL skip START/RUN/DRAIN and go IDLE->DONE; eng_start not asserted.
REQ-010 START: SHALL assert eng_start for exactly one cycle, then enter RUN.
REQ-011 RUN: each eng_new_transaction SHALL increment aw_cnt (8 bit); when eng_new_transaction and eng_last_transaction coincide, SHALL enter DRAIN.
REQ-012 bready SHALL be 1 in RUN and DRAIN, 0 otherwise; each bvalid&&bready SHALL increment b_cnt (8 bit).
REQ-013 eng_enable SHALL be 1 only in RUN while (aw_cnt - b_cnt) < MAX_OUTSTANDING, modulo-256 difference.
REQ-014 Same-cycle AW and B events SHALL update both counters; difference unchanged.
REQ-015 DRAIN: when b_cnt equals aw_cnt (including the B handshake in that cycle) SHALL enter DONE.
REQ-016 DONE: SHALL pulse done[latched grant] one cycle, clear aw_cnt/b_cnt, return IDLE; new grant earliest next cycle.
REQ-017 busy SHALL be 1 in every state except IDLE.
REQ-018 req_ready SHALL be 0 outside the IDLE grant cycle; requesters SHALL hold req_valid and payload until accepted.
REQ-019 B response received while aw_cnt==b_cnt SHALL be ignored (counter not incremented).

Reset
REQ-020 On rst assertion, state SHALL go IDLE immediately, irrespective of clk.
REQ-021 Reset values: req_ready=0, done=0, eng_start=0, eng_enable=0, bready=0, busy=0, eng_start_addr=0, eng_btt=0, counters 0, last_grant=NUM_REQ-1.
REQ-022 Reset mid-command SHALL abandon it with no done pulse.

Structure
REQ-023 State enum and counter width constant SHALL live in shared package redma_sched_pkg.
REQ-024 Round-robin grant logic SHALL be a sub-module rr_arbiter (req vector, advance, grant one-hot, grant index).

Verification
REQ-025 Single req0 addr=0x1000 btt=512, engine issues 2 bursts, 2 B -> one eng_start, done[0] after 2nd B.
REQ-026 req0..req3 all valid from reset -> grant order 0,1,2,3; then req1 and req3 valid -> 1 then 3.
REQ-027 MAX_OUTSTANDING=2, engine 5 bursts, B delayed 20 cycles -> eng_enable low when aw_cnt-b_cnt=2, never 3 outstanding.
REQ-028 req2 btt=0 -> req_ready[2] then done[2] next cycle, eng_start never asserted.
REQ-029 AW and B on same cycle with 1 outstanding -> difference stays 1, DRAIN exits on final B.
REQ-030 rst asserted in RUN with 3 outstanding -> all outputs at reset values asynchronously, no done pulse, next command served normally.
